// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready request into one SETUP/ACCESS transfer and returns
// a held response. Single outstanding transfer; ACCESS aborted after TIMEOUT unready cycles.
module apb4_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // request
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   input  logic [2:0]              req_prot_i,
   // response
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   // APB4
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [2:0]              pprot_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int unsigned StrbW = DATA_WIDTH / 8;
   localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [StrbW-1:0]      strb_q, strb_d;
   logic [2:0]            prot_q, prot_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  timeout_q, timeout_d;
   logic [CntW-1:0]       cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      prot_d    = prot_q;
      write_d   = write_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               // Reads never present byte strobes on the bus.
               strb_d  = req_write_i ? req_strb_i : '0;
               prot_d  = req_prot_i;
               write_d = req_write_i;
               cnt_d   = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            if (pready_i) begin
               rdata_d   = write_q ? '0 : prdata_i;
               err_d     = pslverr_i;
               timeout_d = 1'b0;
               state_d   = StResp;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prot_q    <= '0;
         write_q   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         prot_q    <= prot_d;
         write_q   <= write_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      req_ready_o   = (state_q == StIdle);
      rsp_valid_o   = (state_q == StResp);
      rsp_rdata_o   = rdata_q;
      rsp_err_o     = err_q;
      rsp_timeout_o = timeout_q;
      psel_o        = (state_q == StSetup) || (state_q == StAccess);
      penable_o     = (state_q == StAccess);
      paddr_o       = addr_q;
      pprot_o       = prot_q;
      pwrite_o      = write_q;
      pwdata_o      = wdata_q;
      pstrb_o       = strb_q;
   end

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master: vector table of complete transfers plus a
// hand-written reset-during-ACCESS sequence. TIMEOUT is set to 4.
module tb_apb4_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic [2:0]  req_prot = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] paddr, pwdata, prdata = '0;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
   logic [3:0]  pstrb;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .req_prot_i(req_prot),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
      .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;   // unready ACCESS cycles before pready (>= 4 means timeout)
      logic [31:0] prdata;
      logic        slverr;
      int          hold;    // cycles rsp_ready held low in RESP
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int k;
      int exp_acc;
      logic [3:0] exp_strb;
      exp_strb = v.write ? v.strb : 4'h0;
      exp_acc  = v.exp_to ? 4 : v.waits + 1;

      @(negedge clk);
      chk($sformatf("v%0d idle req_ready", idx), req_ready, 1);
      req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
      req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;

      @(negedge clk);  // SETUP
      req_valid = 1'b0;
      chk($sformatf("v%0d setup psel/penable", idx), {psel, penable}, 2'b10);
      chk($sformatf("v%0d setup paddr", idx), paddr, v.addr);
      chk($sformatf("v%0d setup pwrite", idx), pwrite, v.write);
      chk($sformatf("v%0d setup pwdata", idx), pwdata, v.wdata);
      chk($sformatf("v%0d setup pstrb", idx), pstrb, exp_strb);
      chk($sformatf("v%0d setup pprot", idx), pprot, v.prot);
      // Bus activity outside ACCESS must be ignored.
      pready = 1'b1; prdata = 32'hBAD0BAD0; pslverr = 1'b1;

      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (!(psel && penable)) break;
         chk($sformatf("v%0d access paddr c%0d", idx, k), {paddr, pstrb}, {v.addr, exp_strb});
         pready  = (k == v.waits);
         prdata  = v.prdata;
         pslverr = v.slverr;
         k++;
      end
      chk($sformatf("v%0d access cycles", idx), k, exp_acc);
      pready = 1'b1; prdata = 32'hFFFFFFFF; pslverr = 1'b0;

      chk($sformatf("v%0d rsp_valid", idx), rsp_valid, 1);
      chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d rsp_err/timeout", idx), {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});

      for (int h = 0; h < v.hold; h++) begin
         req_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d hold%0d rsp", idx, h),
             {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
             {1'b1, v.exp_rdata, v.exp_err, v.exp_to});
         chk($sformatf("v%0d hold%0d req_ready/psel", idx, h), {req_ready, psel}, 2'b00);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      pready = 1'b0;
      chk($sformatf("v%0d back idle", idx), {rsp_valid, req_ready, psel}, 3'b010);
   endtask

   initial begin
      //            wr    addr   wdata         strb  prot waits prdata       err hold rdata        e  to
      vecs[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'h0, 0,  32'h55555555, 1'b0, 0, 32'h0,        1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 3'h2, 99, 32'hAAAAAAAA, 1'b0, 0, 32'h0,        1'b1, 1'b1};
      vecs[2] = '{1'b0, 32'h00, 32'h11111111, 4'hF, 3'h1, 3,  32'h12345678, 1'b0, 0, 32'h12345678, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 3'h0, 1,  32'hCAFE0001, 1'b1, 1, 32'hCAFE0001, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'h08, 32'h0BADF00D, 4'h3, 3'h5, 0,  32'h0,        1'b0, 5, 32'h0,        1'b0, 1'b0};
      vecs[5] = '{1'b1, 32'h3C, 32'h87654321, 4'hC, 3'h7, 2,  32'h13579BDF, 1'b1, 0, 32'h0,        1'b1, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset req_ready/rsp", {req_ready, rsp_valid, rsp_err, rsp_timeout}, 4'b1000);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset bus ctl", {psel, penable, pwrite, pstrb, pprot}, 0);
      chk("reset paddr/pwdata", {paddr, pwdata}, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Reset during ACCESS abandons the transfer.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'h1; req_strb = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst-mid access state", {psel, penable}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst-mid bus idle", {psel, penable}, 2'b00);
      chk("rst-mid req_ready/rsp_valid", {req_ready, rsp_valid}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         pready = 1'b1;
         @(negedge clk);
         chk($sformatf("rst-mid quiet c%0d", i), {rsp_valid, psel, req_ready}, 3'b001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
